// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the transmitter stage: frame
// levels, the default data width and the receiver state encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  localparam int UART_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Mid-bit sample timer. While restart is high the timer is held at the start of a bit.
// It then ticks once at cycle CLKS_PER_BIT/2 and every CLKS_PER_BIT cycles after that.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic restart,
  output logic sample_tick
);

  localparam int HALF       = CLKS_PER_BIT / 2;
  localparam int CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int FIRST_LAST = (HALF > 0) ? HALF - 1 : 0;

  localparam logic [CW-1:0] FIRST_TERM = CW'(FIRST_LAST);
  localparam logic [CW-1:0] BIT_TERM   = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;
  logic          first;

  assign sample_tick = !restart && (cnt == (first ? FIRST_TERM : BIT_TERM));

  // With a zero half-bit offset the start sample coincides with the restart edge,
  // so the shortened first interval is skipped entirely.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt   <= '0;
      first <= 1'b1;
    end else if (restart) begin
      cnt   <= '0;
      first <= (HALF != 0);
    end else if (sample_tick) begin
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start bit, DATA_WIDTH bits MSB first, one checked stop bit.
// Define UART_RX_SYNC_EN to pass rx through a two-flop synchroniser (adds 2 cycles).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  framing_error
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  rx_state_t             state;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  rx_s;
  logic                  restart;
  logic                  sample_tick;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_ff;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_ff <= {2{UART_IDLE_LEVEL}};
    end else begin
      sync_ff <= {sync_ff[0], rx};
    end
  end

  assign rx_s = sync_ff[1];
`else
  assign rx_s = rx;
`endif

  // The timer is parked while waiting for a start edge so it is aligned to it.
  assign restart = (state == IDLE) || (state == WAIT_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK        (CLK),
    .RESET      (RESET),
    .restart    (restart),
    .sample_tick(sample_tick)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      data          <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      valid         <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_s == UART_START_BIT) begin
            if (CLKS_PER_BIT == 1) begin
              state   <= DATA;
              bit_cnt <= LAST_BIT;
            end else begin
              state   <= START;
            end
          end
        end
        START: begin
          if (sample_tick) begin
            if (rx_s == UART_START_BIT) begin
              state   <= DATA;
              bit_cnt <= LAST_BIT;
            end else begin
              state   <= IDLE;
            end
          end
        end
        DATA: begin
          if (sample_tick) begin
            shift <= {shift[DATA_WIDTH-2:0], rx_s};
            if (bit_cnt == '0) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        STOP: begin
          if (sample_tick) begin
            if (rx_s == UART_STOP_BIT) begin
              data  <= shift;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s == UART_IDLE_LEVEL) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 1 and 4 clocks per bit; expected bytes,
// error flags and pulse cycles are queued by the frame driver and popped by monitors.
module tb_uart_receiver;

`ifdef UART_RX_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif

  typedef struct {
    bit         err;
    logic [7:0] byte_val;
    int         due;
  } exp_t;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic       rx1   = 1'b1;
  logic       rx4   = 1'b1;
  logic [7:0] data1, data4;
  logic       valid1, valid4, ferr1, ferr4;

  exp_t       q1[$];
  exp_t       q4[$];
  logic [7:0] model1 = 8'h00;
  logic [7:0] model4 = 8'h00;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  uart_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .rx(rx1),
    .data(data1), .valid(valid1), .framing_error(ferr1)
  );

  uart_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .rx(rx4),
    .data(data4), .valid(valid4), .framing_error(ferr4)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive(input int which, input logic v, input int n);
    if (which == 1) rx1 = v;
    else            rx4 = v;
    tick_n(n);
  endtask

  // Sends one frame. The expected pulse lands one cycle after the stop-bit
  // sample edge, which sits at 9 bit periods plus half a bit after the start edge.
  task automatic applyStimulus(input int which, input logic [7:0] b,
                               input bit bad_stop, input int low_hold);
    int   n;
    exp_t e;
    n          = (which == 1) ? 1 : 4;
    e.err      = bad_stop;
    e.byte_val = b;
    e.due      = cyc + 1 + 9 * n + n / 2 + SYNC_DLY;
    if (which == 1) q1.push_back(e);
    else            q4.push_back(e);
    drive(which, 1'b0, n);
    for (int i = 7; i >= 0; i--) drive(which, b[i], n);
    if (bad_stop) begin
      drive(which, 1'b0, n + low_hold);
      drive(which, 1'b1, 1);
    end else begin
      drive(which, 1'b1, n);
    end
  endtask

  task automatic check_port(input int which);
    logic       v, f;
    logic [7:0] d;
    exp_t       e;
    int         qsize;
    v     = (which == 1) ? valid1 : valid4;
    f     = (which == 1) ? ferr1  : ferr4;
    d     = (which == 1) ? data1  : data4;
    qsize = (which == 1) ? q1.size() : q4.size();
    if (RESET) begin
      if (which == 1) model1 = 8'h00;
      else            model4 = 8'h00;
    end
    if (v || f) begin
      checkOutput($sformatf("pulse_exclusive%0d", which), int'(v && f), 0);
      if (qsize == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_pulse%0d: got valid=%0b ferr=%0b, want no pulse (cycle %0d)",
                 which, v, f, cyc);
      end else begin
        e = (which == 1) ? q1.pop_front() : q4.pop_front();
        checkOutput($sformatf("pulse_is_error%0d", which), int'(f), int'(e.err));
        checkOutput($sformatf("pulse_cycle%0d", which), cyc, e.due);
        if (!e.err) begin
          if (which == 1) model1 = e.byte_val;
          else            model4 = e.byte_val;
        end
      end
    end
    checkOutput($sformatf("data%0d", which), int'(d), int'((which == 1) ? model1 : model4));
  endtask

  always @(negedge CLK) begin
    check_port(1);
    check_port(4);
  end

  task automatic wait_drain();
    int w;
    w = 0;
    while ((q1.size() + q4.size()) != 0 && w < 200) begin
      tick_n(1);
      w++;
    end
    checkOutput("drain_pending", q1.size() + q4.size(), 0);
  endtask

  task automatic random_frames(input int which, input int count);
    logic [7:0] b;
    bit         bs;
    for (int i = 0; i < count; i++) begin
      b  = 8'($urandom_range(0, 255));
      bs = ($urandom_range(0, 5) == 0);
      applyStimulus(which, b, bs, $urandom_range(0, 4));
      drive(which, 1'b1, $urandom_range(0, 3));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] aborted;
    aborted = 8'h55;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_valid", int'(valid1), 0);
    checkOutput("reset_ferr", int'(ferr1), 0);
    checkOutput("reset_data", int'(data1), 0);
    RESET = 1'b0;

    // Idle line: monitors flag any pulse or data change.
    tick_n(20);
    checkOutput("idle_data", int'(data1), 0);

    applyStimulus(1, 8'hA5, 1'b0, 0);
    drive(1, 1'b1, 3);

    applyStimulus(1, 8'h3C, 1'b0, 0);
    applyStimulus(1, 8'hFF, 1'b0, 0);
    drive(1, 1'b1, 3);

    applyStimulus(1, 8'h81, 1'b1, 5);
    applyStimulus(1, 8'h42, 1'b0, 0);
    drive(1, 1'b1, 3);
    wait_drain();

    // Abort a frame after its fifth data bit with a reset pulse.
    drive(1, 1'b0, 1);
    for (int i = 7; i >= 3; i--) drive(1, aborted[i], 1);
    RESET = 1'b1;
    rx1   = 1'b1;
    tick_n(2);
    RESET = 1'b0;
    drive(1, 1'b1, 3);
    applyStimulus(1, 8'h12, 1'b0, 0);
    drive(1, 1'b1, 3);

    random_frames(1, 40);
    drive(1, 1'b1, 4);
    wait_drain();

    // Slow link: a one-cycle glitch must be rejected at the start-bit sample.
    drive(4, 1'b0, 1);
    drive(4, 1'b1, 6);
    applyStimulus(4, 8'hC3, 1'b0, 0);
    drive(4, 1'b1, 4);
    random_frames(4, 12);
    drive(4, 1'b1, 8);
    wait_drain();

    checkOutput("final_q1_empty", q1.size(), 0);
    checkOutput("final_q4_empty", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
